pcm_stream_buffer: RTL
======================

PCM_STREAM_BUFFER -- requirements
Module: pcm_stream_buffer

Interface
REQ-001 Parameter SAMPLE_W, default 16: bits per channel sample; SHALL be a multiple of 8 in the range 8..32.
REQ-002 Parameter CHANNELS, default 2: samples per frame; SHALL be 1..8.
REQ-003 Parameter DEPTH_LOG2, default 9: FIFO depth is 2**DEPTH_LOG2 frames.
REQ-004 clk  input  1: single system clock (27 MHz); all logic on rising edge.
REQ-005 rst_n  input  1: asynchronous, active-low reset.
REQ-006 byte_in  input  8: received stream byte.
REQ-007 byte_ready  input  1: one-cycle strobe, byte_in valid.
REQ-008 sample_tick  input  1: one-cycle playback strobe from the I2S driver.
REQ-009 mono_sample  output  CHANNELS*SAMPLE_W: current frame; channel 0 in the LSBs.
REQ-010 sample_valid  output  1: one-cycle pulse when mono_sample updates from the FIFO.
REQ-011 level  output  DEPTH_LOG2+1: frames currently stored.
REQ-012 underrun  output  1: one-cycle pulse, tick served with the FIFO empty.
REQ-013 overflow  output  1: sticky; a completed frame was dropped because the FIFO was full.

Function
REQ-014 Byte assembly: bytes are little-endian within a sample, channel 0 first; the byte counter runs 0..CHANNELS*SAMPLE_W/8-1 and wraps.
REQ-015 On the byte_ready that completes a frame, the frame SHALL be written in the same cycle the counter wraps; it becomes readable on the next cycle.
REQ-016 Completed frame with level == 2**DEPTH_LOG2: frame discarded, overflow set, counter still wraps; FIFO contents unchanged.
REQ-017 sample_tick with level > 0 (and playback enabled): pop the oldest frame; mono_sample updates and sample_valid pulses exactly 1 cycle after the tick.
REQ-018 sample_tick with level == 0 or playback disabled: mono_sample is held at its previous value, no sample_valid, and underrun pulses 1 cycle after the tick.
REQ-019 Simultaneous frame write and pop in one cycle: both take effect; level unchanged; when full, the pop frees space, so the write is accepted.
REQ-020 A simultaneous write and pop when empty: the pop is treated as an underrun; the write lands and level becomes 1.
REQ-021 Read/write pointers are DEPTH_LOG2+1 bits and wrap modulo 2**(DEPTH_LOG2+1); level = wr_ptr - rd_ptr.
REQ-022 Storage SHALL be a synchronous-read array that infers block RAM (Gowin BSRAM); output registered.
REQ-023 byte_ready and sample_tick are independent and may coincide with any state.

Reset
REQ-024 While rst_n is low: pointers, byte counter and level are 0; mono_sample is 0; sample_valid, underrun and overflow are 0; a partially assembled frame is discarded.
REQ-025 Reset asserted mid-frame or mid-pop SHALL abort without a write or sample_valid; RAM contents need not be cleared.
REQ-026 After rst_n is released, the first byte_ready is taken as byte 0 of channel 0.

Configuration
REQ-027 Macro PCM_PREFILL_EN defined: a playback-enable flag clears on reset and on every underrun, and sets when level reaches 2**(DEPTH_LOG2-1); while clear, ticks follow REQ-018.
REQ-028 PCM_PREFILL_EN undefined: playback is always enabled; pops start with the first tick after level > 0.

Verification
REQ-029 Defaults, no macro: 4 bytes 34 12 78 56, then tick -> 1 cycle later mono_sample = 0x56781234, sample_valid = 1, level 1 -> 0.
REQ-030 Tick with the FIFO empty after reset -> underrun pulse; mono_sample stays 0; no sample_valid.
REQ-031 DEPTH_LOG2 = 2: write 5 frames -> level = 4, overflow = 1; 4 ticks return frames 1..4 in order; the 5th tick gives underrun.
REQ-032 Level 4 (full) with frame completion and tick in the same cycle -> frame accepted, level stays 4, overflow stays 0.
REQ-033 Send 2 bytes, pulse rst_n low, then send 4 bytes 01 00 02 00 and tick -> mono_sample = 0x00020001.
REQ-034 PCM_PREFILL_EN, DEPTH_LOG2 = 3: 3 frames + ticks -> underrun only; after the 4th frame, ticks pop; draining to empty and ticking again -> underrun, then pops resume only after level reaches 4.

Source files
------------

// File: rtl/pcm_stream_buffer.sv
// Purpose: assembles little-endian PCM bytes into frames and buffers them in a BSRAM FIFO for I2S playback.
// Latency: a completed frame is readable the cycle after its last byte; a tick yields mono_sample/sample_valid 1 cycle later.
// Backpressure: none upstream; a frame completed into a full FIFO is dropped (sticky overflow); a tick with nothing to play pulses underrun.
// Optional feature: define PCM_PREFILL_EN to hold playback off until the FIFO is half full, re-arming after every underrun.
module pcm_stream_buffer #(
    parameter int SAMPLE_W   = 16,
    parameter int CHANNELS   = 2,
    parameter int DEPTH_LOG2 = 9
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [7:0]                   byte_in,
    input  logic                         byte_ready,
    input  logic                         sample_tick,
    output logic [CHANNELS*SAMPLE_W-1:0] mono_sample,
    output logic                         sample_valid,
    output logic [DEPTH_LOG2:0]          level,
    output logic                         underrun,
    output logic                         overflow
);
    localparam int FRAME_W = CHANNELS * SAMPLE_W;
    localparam int BYTES   = FRAME_W / 8;
    localparam int CNT_W   = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LVL  = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [CNT_W-1:0]    LAST_BYTE = CNT_W'(BYTES - 1);

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [FRAME_W-1:0]      asm_q, asm_d;
    logic [DEPTH_LOG2:0]     wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0]     rd_ptr_q, rd_ptr_d;
    logic                    ovf_q, ovf_d;
    logic                    vld_q, vld_d;
    logic                    und_q, und_d;
    logic                    have_q, have_d;
    logic                    play_en;

    logic [FRAME_W+7:0]      frame_shift;
    logic [FRAME_W-1:0]      frame_dat;
    logic [DEPTH_LOG2:0]     level_cur;
    logic                    frame_done;
    logic                    fifo_full;
    logic                    pop;
    logic                    wr_en;

    logic [FRAME_W-1:0]      mem [DEPTH];
    logic [FRAME_W-1:0]      rd_dat_q;

    // Byte assembly, FIFO control and output strobes for the coming edge.
    always_comb begin
        frame_shift = {byte_in, asm_q};
        frame_dat   = frame_shift[FRAME_W+7:8];
        frame_done  = byte_ready && (cnt_q == LAST_BYTE);
        level_cur   = wr_ptr_q - rd_ptr_q;
        fifo_full   = (level_cur == FULL_LVL);
        pop         = sample_tick && (level_cur != '0) && play_en;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts the frame.
        wr_en       = frame_done && (!fifo_full || pop) && rst_n;

        cnt_d    = cnt_q;
        asm_d    = asm_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        vld_d    = pop;
        und_d    = sample_tick && !pop;
        have_d   = have_q || pop;

        if (byte_ready) begin
            asm_d = frame_dat;
            cnt_d = frame_done ? '0 : cnt_q + 1'b1;
        end
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (frame_done && fifo_full && !pop) begin
            ovf_d = 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Control and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            asm_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            vld_q    <= 1'b0;
            und_q    <= 1'b0;
            have_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            asm_q    <= asm_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            vld_q    <= vld_d;
            und_q    <= und_d;
            have_q   <= have_d;
        end
    end

    // Frame store: read-before-write so a full-FIFO write+pop returns the old oldest frame.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= frame_dat;
        end
        if (pop) begin
            rd_dat_q <= mem[rd_ptr_q[DEPTH_LOG2-1:0]];
        end
    end

`ifdef PCM_PREFILL_EN
    localparam logic [DEPTH_LOG2:0] HALF_LVL = (DEPTH_LOG2 + 1)'(DEPTH / 2);
    logic play_en_q, play_en_d;

    // Playback gate: drops on any underrun, re-arms once half the FIFO is filled.
    always_comb begin
        play_en_d = play_en_q;
        if (sample_tick && !pop) begin
            play_en_d = 1'b0;
        end else if (level_cur >= HALF_LVL) begin
            play_en_d = 1'b1;
        end
    end

    // Playback gate register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            play_en_q <= 1'b0;
        end else begin
            play_en_q <= play_en_d;
        end
    end

    assign play_en = play_en_q;
`else
    assign play_en = 1'b1;
`endif

    // The RAM output register has no reset; mask it until the first real pop.
    assign mono_sample  = have_q ? rd_dat_q : '0;
    assign sample_valid = vld_q;
    assign underrun     = und_q;
    assign overflow     = ovf_q;
    assign level        = level_cur;
endmodule
